// File: rtl/nx_node_decoder_pkg.sv
// Shared constants for the mesh node inbound decoder.
// Command and direction encodings plus default field widths.
package nx_node_decoder_pkg;

    localparam int STREAM_W = 32;
    localparam int ROW_W    = 4;
    localparam int COL_W    = 4;
    localparam int CMD_W    = 2;
    localparam int N_INPUTS = 8;
    localparam int N_OUTS   = 8;
    localparam int INSTR_W  = 15;

    typedef enum logic [1:0] {
        CMD_LOAD_INSTR = 2'd0,
        CMD_MAP_IO     = 2'd1,
        CMD_SIG_STATE  = 2'd2,
        CMD_RESERVED   = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    // Straight-through continuation of a message arriving from d.
    function automatic logic [1:0] dir_through(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction

endpackage

// File: rtl/nx_route_dir.sv
// Dimension-ordered route choice: rows first, then columns.
// Pure combinational; shared with the node control output path.
module nx_route_dir
    import nx_node_decoder_pkg::*;
#(
    parameter int ROW_WIDTH = ROW_W,
    parameter int COL_WIDTH = COL_W
) (
    input  logic [ROW_WIDTH-1:0] tgt_row,
    input  logic [COL_WIDTH-1:0] tgt_col,
    input  logic [ROW_WIDTH-1:0] node_row,
    input  logic [COL_WIDTH-1:0] node_col,
    output logic [1:0]           dir
);

    // Pick the outbound port toward the target node
    always_comb begin
        dir = DIR_E;
        if (tgt_row < node_row) begin
            dir = DIR_N;
        end else if (tgt_row > node_row) begin
            dir = DIR_S;
        end else if (tgt_col < node_col) begin
            dir = DIR_W;
        end
    end

endmodule

// File: rtl/nx_node_decoder.sv
// Inbound message decoder and bypass scheduler for one mesh node.
// Local messages become one-cycle strobes; others go out on the bypass.
module nx_node_decoder
    import nx_node_decoder_pkg::*;
#(
    parameter int STREAM_WIDTH   = STREAM_W,
    parameter int ADDR_ROW_WIDTH = ROW_W,
    parameter int ADDR_COL_WIDTH = COL_W,
    parameter int COMMAND_WIDTH  = CMD_W,
    parameter int INPUTS         = N_INPUTS,
    parameter int OUTPUTS        = N_OUTS,
    parameter int INSTR_WIDTH    = INSTR_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
    input  logic [STREAM_WIDTH-1:0]   in_data_i,
    input  logic [1:0]                in_dir_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [STREAM_WIDTH-1:0]   byp_data_o,
    output logic [1:0]                byp_dir_o,
    output logic                      byp_valid_o,
    input  logic                      byp_ready_i,
    output logic [$clog2(OUTPUTS)-1:0] map_io_o,
    output logic                      map_input_o,
    output logic [ADDR_ROW_WIDTH-1:0] map_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] map_remote_col_o,
    output logic [$clog2(INPUTS)-1:0] map_remote_idx_o,
    output logic                      map_slot_o,
    output logic                      map_broadcast_o,
    output logic                      map_seq_o,
    output logic                      map_valid_o,
    output logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] signal_remote_col_o,
    output logic [$clog2(INPUTS)-1:0] signal_remote_idx_o,
    output logic                      signal_state_o,
    output logic                      signal_valid_o,
    output logic [INSTR_WIDTH-1:0]    instr_data_o,
    output logic                      instr_valid_o,
    output logic [7:0]                drop_count_o
);

    localparam int RW   = ADDR_ROW_WIDTH;
    localparam int CW   = ADDR_COL_WIDTH;
    localparam int PW   = STREAM_WIDTH - 1 - RW - CW - COMMAND_WIDTH;
    localparam int IO_W = $clog2(OUTPUTS);
    localparam int IX_W = $clog2(INPUTS);

    // Header bit positions
    localparam int BC_POS = STREAM_WIDTH - 1;
    localparam int ROW_HI = STREAM_WIDTH - 2;
    localparam int COL_HI = ROW_HI - RW;
    localparam int CMD_HI = COL_HI - CW;

    // Mapping payload bit positions, MSB first
    localparam int M_IO_HI  = PW - 1;
    localparam int M_IN     = M_IO_HI - IO_W;
    localparam int M_ROW_HI = M_IN - 1;
    localparam int M_COL_HI = M_ROW_HI - RW;
    localparam int M_IDX_HI = M_COL_HI - CW;
    localparam int M_SLOT   = M_IDX_HI - IX_W;
    localparam int M_BC     = M_SLOT - 1;
    localparam int M_SEQ    = M_BC - 1;

    // Signal payload bit positions, MSB first
    localparam int S_ROW_HI = PW - 1;
    localparam int S_COL_HI = S_ROW_HI - RW;
    localparam int S_IDX_HI = S_COL_HI - CW;
    localparam int S_STATE  = S_IDX_HI - IX_W;

    logic          hdr_bc;
    logic [RW-1:0] hdr_row;
    logic [CW-1:0] hdr_col;
    cmd_e          cmd;
    logic [1:0]    route_dir;

    logic is_self;
    logic is_local;
    logic bc_sig;
    logic want_fwd;
    logic want_map;
    logic want_sig;
    logic want_instr;
    logic want_drop;
    logic accept;

    logic                    byp_valid_d, byp_valid_q;
    logic [STREAM_WIDTH-1:0] byp_data_d, byp_data_q;
    logic [1:0]              byp_dir_d, byp_dir_q;

    logic            map_valid_d, map_valid_q;
    logic [IO_W-1:0] map_io_d, map_io_q;
    logic            map_input_d, map_input_q;
    logic [RW-1:0]   map_row_d, map_row_q;
    logic [CW-1:0]   map_col_d, map_col_q;
    logic [IX_W-1:0] map_idx_d, map_idx_q;
    logic            map_slot_d, map_slot_q;
    logic            map_bc_d, map_bc_q;
    logic            map_seq_d, map_seq_q;

    logic            sig_valid_d, sig_valid_q;
    logic [RW-1:0]   sig_row_d, sig_row_q;
    logic [CW-1:0]   sig_col_d, sig_col_q;
    logic [IX_W-1:0] sig_idx_d, sig_idx_q;
    logic            sig_state_d, sig_state_q;

    logic                   instr_valid_d, instr_valid_q;
    logic [INSTR_WIDTH-1:0] instr_data_d, instr_data_q;

    logic [7:0] drop_count_d, drop_count_q;

    assign hdr_bc  = in_data_i[BC_POS];
    assign hdr_row = in_data_i[ROW_HI -: RW];
    assign hdr_col = in_data_i[COL_HI -: CW];
    assign cmd     = cmd_e'(in_data_i[CMD_HI -: COMMAND_WIDTH]);

    nx_route_dir #(
        .ROW_WIDTH (RW),
        .COL_WIDTH (CW)
    ) u_route_dir (
        .tgt_row  (hdr_row),
        .tgt_col  (hdr_col),
        .node_row (node_row_i),
        .node_col (node_col_i),
        .dir      (route_dir)
    );

    // Classify the inbound message into the actions it needs
    always_comb begin
        is_self    = (hdr_row == node_row_i) && (hdr_col == node_col_i);
        is_local   = !hdr_bc && is_self;
        bc_sig     = hdr_bc && (cmd == CMD_SIG_STATE);
        want_fwd   = (!hdr_bc && !is_self) || bc_sig;
        want_map   = is_local && (cmd == CMD_MAP_IO);
        want_sig   = (is_local && (cmd == CMD_SIG_STATE)) || bc_sig;
        want_instr = is_local && (cmd == CMD_LOAD_INSTR);
        want_drop  = (is_local && (cmd == CMD_RESERVED)) || (hdr_bc && !bc_sig);
    end

    // Any message waits while the bypass is stalled so order is kept
    assign in_ready_o = !byp_valid_q || byp_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // Next-state for bypass slot, strobes and drop counter
    always_comb begin
        byp_valid_d = byp_valid_q;
        byp_data_d  = byp_data_q;
        byp_dir_d   = byp_dir_q;
        if (byp_ready_i) begin
            byp_valid_d = 1'b0;
        end
        if (accept && want_fwd) begin
            byp_valid_d = 1'b1;
            byp_data_d  = in_data_i;
            byp_dir_d   = hdr_bc ? dir_through(in_dir_i) : route_dir;
        end

        map_valid_d = accept && want_map;
        map_io_d    = map_io_q;
        map_input_d = map_input_q;
        map_row_d   = map_row_q;
        map_col_d   = map_col_q;
        map_idx_d   = map_idx_q;
        map_slot_d  = map_slot_q;
        map_bc_d    = map_bc_q;
        map_seq_d   = map_seq_q;
        if (map_valid_d) begin
            map_io_d    = in_data_i[M_IO_HI -: IO_W];
            map_input_d = in_data_i[M_IN];
            map_row_d   = in_data_i[M_ROW_HI -: RW];
            map_col_d   = in_data_i[M_COL_HI -: CW];
            map_idx_d   = in_data_i[M_IDX_HI -: IX_W];
            map_slot_d  = in_data_i[M_SLOT];
            map_bc_d    = in_data_i[M_BC];
            map_seq_d   = in_data_i[M_SEQ];
        end

        sig_valid_d = accept && want_sig;
        sig_row_d   = sig_row_q;
        sig_col_d   = sig_col_q;
        sig_idx_d   = sig_idx_q;
        sig_state_d = sig_state_q;
        if (sig_valid_d) begin
            sig_row_d   = in_data_i[S_ROW_HI -: RW];
            sig_col_d   = in_data_i[S_COL_HI -: CW];
            sig_idx_d   = in_data_i[S_IDX_HI -: IX_W];
            sig_state_d = in_data_i[S_STATE];
        end

        instr_valid_d = accept && want_instr;
        instr_data_d  = instr_data_q;
        if (instr_valid_d) begin
            instr_data_d = in_data_i[PW-1 -: INSTR_WIDTH];
        end

        drop_count_d = drop_count_q;
        if (accept && want_drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byp_valid_q   <= 1'b0;
            byp_data_q    <= '0;
            byp_dir_q     <= DIR_N;
            map_valid_q   <= 1'b0;
            map_io_q      <= '0;
            map_input_q   <= 1'b0;
            map_row_q     <= '0;
            map_col_q     <= '0;
            map_idx_q     <= '0;
            map_slot_q    <= 1'b0;
            map_bc_q      <= 1'b0;
            map_seq_q     <= 1'b0;
            sig_valid_q   <= 1'b0;
            sig_row_q     <= '0;
            sig_col_q     <= '0;
            sig_idx_q     <= '0;
            sig_state_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            drop_count_q  <= '0;
        end else begin
            byp_valid_q   <= byp_valid_d;
            byp_data_q    <= byp_data_d;
            byp_dir_q     <= byp_dir_d;
            map_valid_q   <= map_valid_d;
            map_io_q      <= map_io_d;
            map_input_q   <= map_input_d;
            map_row_q     <= map_row_d;
            map_col_q     <= map_col_d;
            map_idx_q     <= map_idx_d;
            map_slot_q    <= map_slot_d;
            map_bc_q      <= map_bc_d;
            map_seq_q     <= map_seq_d;
            sig_valid_q   <= sig_valid_d;
            sig_row_q     <= sig_row_d;
            sig_col_q     <= sig_col_d;
            sig_idx_q     <= sig_idx_d;
            sig_state_q   <= sig_state_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign byp_valid_o         = byp_valid_q;
    assign byp_data_o          = byp_data_q;
    assign byp_dir_o           = byp_dir_q;
    assign map_valid_o         = map_valid_q;
    assign map_io_o            = map_io_q;
    assign map_input_o         = map_input_q;
    assign map_remote_row_o    = map_row_q;
    assign map_remote_col_o    = map_col_q;
    assign map_remote_idx_o    = map_idx_q;
    assign map_slot_o          = map_slot_q;
    assign map_broadcast_o     = map_bc_q;
    assign map_seq_o           = map_seq_q;
    assign signal_valid_o      = sig_valid_q;
    assign signal_remote_row_o = sig_row_q;
    assign signal_remote_col_o = sig_col_q;
    assign signal_remote_idx_o = sig_idx_q;
    assign signal_state_o      = sig_state_q;
    assign instr_valid_o       = instr_valid_q;
    assign instr_data_o        = instr_data_q;
    assign drop_count_o        = drop_count_q;

endmodule

// File: tb/tb_nx_node_decoder.sv
// Bench for nx_node_decoder: directed scenarios then random traffic.
// A message-level reference model predicts every output.
module tb_nx_node_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  node_row = 4'd2;
    logic [3:0]  node_col = 4'd3;
    logic [31:0] in_data = '0;
    logic [1:0]  in_dir = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] byp_data;
    logic [1:0]  byp_dir;
    logic        byp_valid;
    logic        byp_ready = 1'b0;
    logic [2:0]  map_io;
    logic        map_input;
    logic [3:0]  map_row;
    logic [3:0]  map_col;
    logic [2:0]  map_idx;
    logic        map_slot;
    logic        map_bc;
    logic        map_seq;
    logic        map_valid;
    logic [3:0]  sig_row;
    logic [3:0]  sig_col;
    logic [2:0]  sig_idx;
    logic        sig_state;
    logic        sig_valid;
    logic [14:0] instr_data;
    logic        instr_valid;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    nx_node_decoder dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .node_row_i          (node_row),
        .node_col_i          (node_col),
        .in_data_i           (in_data),
        .in_dir_i            (in_dir),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .byp_data_o          (byp_data),
        .byp_dir_o           (byp_dir),
        .byp_valid_o         (byp_valid),
        .byp_ready_i         (byp_ready),
        .map_io_o            (map_io),
        .map_input_o         (map_input),
        .map_remote_row_o    (map_row),
        .map_remote_col_o    (map_col),
        .map_remote_idx_o    (map_idx),
        .map_slot_o          (map_slot),
        .map_broadcast_o     (map_bc),
        .map_seq_o           (map_seq),
        .map_valid_o         (map_valid),
        .signal_remote_row_o (sig_row),
        .signal_remote_col_o (sig_col),
        .signal_remote_idx_o (sig_idx),
        .signal_state_o      (sig_state),
        .signal_valid_o      (sig_valid),
        .instr_data_o        (instr_data),
        .instr_valid_o       (instr_valid),
        .drop_count_o        (drop_count)
    );

    int total = 0;
    int bad = 0;

    // Reference model state
    logic        m_byp_v;
    logic [31:0] m_byp_d;
    int          m_byp_dir;
    logic        m_map_v;
    int          m_io, m_input, m_mrow, m_mcol, m_midx, m_slot, m_mbc, m_seq;
    logic        m_sig_v;
    int          m_srow, m_scol, m_sidx, m_state;
    logic        m_instr_v;
    int          m_instr;
    int          m_drops;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int bc, input int row, input int col,
                                       input int cmd, input logic [31:0] p);
        return (32'(bc) << 31) | (32'(row) << 27) | (32'(col) << 23) |
               (32'(cmd) << 21) | (p & 32'h1F_FFFF);
    endfunction

    function automatic int route(input int tr, input int tc, input int nr, input int nc);
        if (tr < nr) return 0;
        if (tr > nr) return 2;
        if (tc < nc) return 3;
        return 1;
    endfunction

    task automatic model_clear();
        m_byp_v = 0; m_byp_d = '0; m_byp_dir = 0;
        m_map_v = 0; m_sig_v = 0; m_instr_v = 0;
        m_drops = 0;
    endtask

    task automatic compare_all();
        chk("byp_valid", byp_valid, m_byp_v);
        if (m_byp_v) begin
            chk("byp_data", byp_data, m_byp_d);
            chk("byp_dir", byp_dir, m_byp_dir);
        end
        chk("map_valid", map_valid, m_map_v);
        if (m_map_v) begin
            chk("map_io", map_io, m_io);
            chk("map_input", map_input, m_input);
            chk("map_row", map_row, m_mrow);
            chk("map_col", map_col, m_mcol);
            chk("map_idx", map_idx, m_midx);
            chk("map_slot", map_slot, m_slot);
            chk("map_bc", map_bc, m_mbc);
            chk("map_seq", map_seq, m_seq);
        end
        chk("sig_valid", sig_valid, m_sig_v);
        if (m_sig_v) begin
            chk("sig_row", sig_row, m_srow);
            chk("sig_col", sig_col, m_scol);
            chk("sig_idx", sig_idx, m_sidx);
            chk("sig_state", sig_state, m_state);
        end
        chk("instr_valid", instr_valid, m_instr_v);
        if (m_instr_v) chk("instr_data", instr_data, m_instr);
        chk("drop_count", drop_count, m_drops);
    endtask

    // One cycle: drive, check ready, predict, clock, compare
    task automatic step(input logic v, input logic [31:0] d, input logic [1:0] di,
                        input logic rdy);
        logic        exp_rdy;
        logic        acc;
        int          bc, row, col, cmd;
        logic [31:0] p;
        logic        here;
        in_valid = v;
        in_data = d;
        in_dir = di;
        byp_ready = rdy;
        #1;
        exp_rdy = !m_byp_v || rdy;
        chk("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        bc = int'(d >> 31);
        row = int'((d >> 27) & 32'hF);
        col = int'((d >> 23) & 32'hF);
        cmd = int'((d >> 21) & 32'h3);
        p = d & 32'h1F_FFFF;
        here = (bc == 0) && (row == int'(node_row)) && (col == int'(node_col));
        m_map_v = 0;
        m_sig_v = 0;
        m_instr_v = 0;
        if (rdy) m_byp_v = 0;
        if (acc) begin
            if ((bc == 1 && cmd == 2) || (here && cmd == 2)) begin
                m_sig_v = 1;
                m_srow = int'((p >> 17) & 32'hF);
                m_scol = int'((p >> 13) & 32'hF);
                m_sidx = int'((p >> 10) & 32'h7);
                m_state = int'((p >> 9) & 32'h1);
            end
            if (here && cmd == 1) begin
                m_map_v = 1;
                m_io = int'((p >> 18) & 32'h7);
                m_input = int'((p >> 17) & 32'h1);
                m_mrow = int'((p >> 13) & 32'hF);
                m_mcol = int'((p >> 9) & 32'hF);
                m_midx = int'((p >> 6) & 32'h7);
                m_slot = int'((p >> 5) & 32'h1);
                m_mbc = int'((p >> 4) & 32'h1);
                m_seq = int'((p >> 3) & 32'h1);
            end
            if (here && cmd == 0) begin
                m_instr_v = 1;
                m_instr = int'(p >> 6);
            end
            if ((here && cmd == 3) || (bc == 1 && cmd != 2)) begin
                if (m_drops < 255) m_drops++;
            end
            if (bc == 1 && cmd == 2) begin
                m_byp_v = 1; m_byp_d = d; m_byp_dir = int'(di) ^ 2;
            end else if (bc == 0 && !here) begin
                m_byp_v = 1; m_byp_d = d;
                m_byp_dir = route(row, col, int'(node_row), int'(node_col));
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        byp_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        model_clear();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_byp_valid", byp_valid, 0);
        chk("rst_byp_data", byp_data, 0);
        chk("rst_byp_dir", byp_dir, 0);
        chk("rst_map_valid", map_valid, 0);
        chk("rst_map_fields", {map_io, map_input, map_row, map_col, map_idx,
                               map_slot, map_bc, map_seq}, 0);
        chk("rst_sig_valid", sig_valid, 0);
        chk("rst_sig_fields", {sig_row, sig_col, sig_idx, sig_state}, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_data", instr_data, 0);
        chk("rst_drop_count", drop_count, 0);
    endtask

    initial begin
        logic [31:0] m;
        logic [31:0] p;
        int tr[4] = '{0, 4, 2, 2};
        int tc[4] = '{3, 3, 0, 7};
        int td[4] = '{0, 2, 3, 1};

        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Local mapping for node (2,3)
        p = (32'd5 << 18) | (32'd1 << 17) | (32'd1 << 13) | (32'd1 << 9) |
            (32'd2 << 6) | (32'd1 << 3);
        step(1, mk(0, 2, 3, 1, p), 2'd0, 1);
        chk("dir_map_valid", map_valid, 1);
        chk("dir_map_io", map_io, 5);
        chk("dir_map_row", map_row, 1);
        chk("dir_map_seq", map_seq, 1);
        chk("dir_map_nobyp", byp_valid, 0);
        step(0, '0, 2'd0, 1);
        chk("dir_map_once", map_valid, 0);

        // Forwarding in each of the four directions
        for (int i = 0; i < 4; i++) begin
            m = mk(0, tr[i], tc[i], 0, 32'(i * 12345));
            step(1, m, 2'd1, 1);
            chk("dir_fwd_valid", byp_valid, 1);
            chk("dir_fwd_dir", byp_dir, td[i]);
            chk("dir_fwd_data", byp_data, m);
        end
        step(0, '0, 2'd0, 1);

        // Broadcast signal arriving from W goes on to E
        p = (32'd1 << 9) | (32'd7 << 17);
        step(1, mk(1, 9, 9, 2, p), 2'd3, 1);
        chk("dir_bc_sig", sig_valid, 1);
        chk("dir_bc_state", sig_state, 1);
        chk("dir_bc_dir", byp_dir, 1);
        step(0, '0, 2'd0, 1);

        // Stalled bypass holds back a local instruction load
        step(1, mk(0, 0, 3, 2, 32'h55), 2'd0, 0);
        m = mk(0, 2, 3, 0, 32'h1ABCDE);
        step(1, m, 2'd0, 0);
        chk("dir_stall_ready", in_ready, 0);
        step(1, m, 2'd0, 0);
        step(1, m, 2'd0, 1);
        chk("dir_stall_instr", instr_valid, 1);
        chk("dir_stall_data", instr_data, 32'h1ABCDE >> 6);
        step(0, '0, 2'd0, 1);

        // Reserved commands saturate the drop counter
        for (int i = 0; i < 300; i++) begin
            step(1, mk(0, 2, 3, 3, $urandom), 2'(i), 1);
        end
        chk("dir_drop_sat", drop_count, 255);
        step(1, mk(1, 1, 1, 0, 32'h0), 2'd0, 1);
        chk("dir_drop_hold", drop_count, 255);

        // Reset while a held bypass message is stalled
        step(1, mk(0, 5, 5, 1, 32'h1234), 2'd0, 0);
        chk("dir_held", byp_valid, 1);
        do_reset();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int bc, row, col;
            if (n % 600 == 0) begin
                node_row = 4'($urandom_range(0, 15));
                node_col = 4'($urandom_range(0, 15));
            end
            bc = ($urandom % 4 == 0) ? 1 : 0;
            row = ($urandom % 2 == 0) ? int'(node_row) : int'($urandom % 16);
            col = ($urandom % 2 == 0) ? int'(node_col) : int'($urandom % 16);
            step($urandom % 5 != 0, mk(bc, row, col, int'($urandom % 4), $urandom),
                 2'($urandom), $urandom % 3 != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
